// File: rtl/writeback_ctrl.sv
`default_nettype none
// ============================================================================
// writeback_ctrl
// Round-robin sharing of the register-file write port between ALU and LSU,
// plus a busy-register scoreboard that stalls issue on RAW/WAW hazards.
// Revision: 1.0
// ============================================================================
module writeback_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGISTER = 32,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,

    input  logic                    iss_valid_i,
    input  logic [AW-1:0]           iss_rd_addr_i,
    input  logic [AW-1:0]           iss_rs1_addr_i,
    input  logic [AW-1:0]           iss_rs2_addr_i,
    input  logic                    iss_uses_rs1_i,
    input  logic                    iss_uses_rs2_i,
    output logic                    iss_ready_o,

    input  logic                    alu_valid_i,
    input  logic [AW-1:0]           alu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   alu_data_i,
    output logic                    alu_ready_o,

    input  logic                    lsu_valid_i,
    input  logic [AW-1:0]           lsu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_data_i,
    output logic                    lsu_ready_o,

    output logic                    rf_we_o,
    output logic [AW-1:0]           rf_rd_addr_o,
    output logic [DATA_WIDTH-1:0]   rf_rd_o,
    output logic [NUM_REGISTER-1:0] busy_o
);

    typedef enum logic [0:0] {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e                  last_grant_q;
    logic                    rf_we_q;
    logic [AW-1:0]           rf_rd_addr_q;
    logic [DATA_WIDTH-1:0]   rf_rd_q;
    logic [NUM_REGISTER-1:0] busy_q;
    logic [NUM_REGISTER-1:0] busy_d;

    logic                    w_alu_ready;
    logic                    w_lsu_ready;
    logic                    w_alu_xfer;
    logic                    w_lsu_xfer;
    logic [AW-1:0]           w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_wb_en;
    logic                    w_iss_ready;
    logic                    w_iss_set;

    // Grants depend on valids and the pointer only, so ready never waits on data.
    always_comb begin
        w_alu_ready = alu_valid_i && (!lsu_valid_i || (last_grant_q == GRANT_LSU));
        w_lsu_ready = lsu_valid_i && (!alu_valid_i || (last_grant_q == GRANT_ALU));
        w_alu_xfer  = alu_valid_i && w_alu_ready;
        w_lsu_xfer  = lsu_valid_i && w_lsu_ready;
        w_sel_addr  = w_alu_xfer ? alu_rd_addr_i : lsu_rd_addr_i;
        w_sel_data  = w_alu_xfer ? alu_data_i    : lsu_data_i;
        w_wb_en     = (w_alu_xfer || w_lsu_xfer) && (w_sel_addr != '0);
    end

    always_comb begin
        w_iss_ready = !(iss_uses_rs1_i && busy_q[iss_rs1_addr_i])
                   && !(iss_uses_rs2_i && busy_q[iss_rs2_addr_i])
                   && !busy_q[iss_rd_addr_i];
        w_iss_set   = iss_valid_i && w_iss_ready && (iss_rd_addr_i != '0);

        // Set is applied after clear: a new issue to the same register is the newer producer.
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_addr_q] = 1'b0;
        end
        if (w_iss_set) begin
            busy_d[iss_rd_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= GRANT_LSU;
            rf_we_q      <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_rd_q      <= '0;
            busy_q       <= '0;
        end else begin
            if (w_alu_xfer) begin
                last_grant_q <= GRANT_ALU;
            end else if (w_lsu_xfer) begin
                last_grant_q <= GRANT_LSU;
            end
            rf_we_q <= w_wb_en;
            if (w_wb_en) begin
                rf_rd_addr_q <= w_sel_addr;
                rf_rd_q      <= w_sel_data;
            end
            busy_q <= busy_d;
        end
    end

    assign iss_ready_o  = w_iss_ready;
    assign alu_ready_o  = w_alu_ready;
    assign lsu_ready_o  = w_lsu_ready;
    assign rf_we_o      = rf_we_q;
    assign rf_rd_addr_o = rf_rd_addr_q;
    assign rf_rd_o      = rf_rd_q;
    assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// tb_writeback_ctrl
// Vector table, directed corner sequences and a randomized run against a model.
// Revision: 1.0
// ============================================================================
module tb_writeback_ctrl;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk_i;
    logic          rst_n_i;
    logic          iss_valid_i;
    logic [AW-1:0] iss_rd_addr_i, iss_rs1_addr_i, iss_rs2_addr_i;
    logic          iss_uses_rs1_i, iss_uses_rs2_i;
    logic          iss_ready_o;
    logic          alu_valid_i;
    logic [AW-1:0] alu_rd_addr_i;
    logic [DW-1:0] alu_data_i;
    logic          alu_ready_o;
    logic          lsu_valid_i;
    logic [AW-1:0] lsu_rd_addr_i;
    logic [DW-1:0] lsu_data_i;
    logic          lsu_ready_o;
    logic          rf_we_o;
    logic [AW-1:0] rf_rd_addr_o;
    logic [DW-1:0] rf_rd_o;
    logic [NR-1:0] busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    writeback_ctrl #(.DATA_WIDTH(DW), .NUM_REGISTER(NR)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .iss_valid_i(iss_valid_i), .iss_rd_addr_i(iss_rd_addr_i),
        .iss_rs1_addr_i(iss_rs1_addr_i), .iss_rs2_addr_i(iss_rs2_addr_i),
        .iss_uses_rs1_i(iss_uses_rs1_i), .iss_uses_rs2_i(iss_uses_rs2_i),
        .iss_ready_o(iss_ready_o),
        .alu_valid_i(alu_valid_i), .alu_rd_addr_i(alu_rd_addr_i),
        .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_addr_i(lsu_rd_addr_i),
        .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
        .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_o(rf_rd_o),
        .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic          alu_v;  logic [AW-1:0] alu_rd; logic [DW-1:0] alu_d;
        logic          lsu_v;  logic [AW-1:0] lsu_rd; logic [DW-1:0] lsu_d;
        logic          iss_v;  logic [AW-1:0] rd, rs1, rs2; logic u1, u2;
        logic          e_alu, e_lsu, e_iss, e_we, chk_port;
        logic [AW-1:0] e_addr; logic [DW-1:0] e_data; logic [NR-1:0] e_busy;
    } vec_t;

    function automatic vec_t mk(int av, int ard, int ad, int lv, int lrd, int ld,
                                int iv, int ird, int r1, int r2, int u1, int u2,
                                int ea, int el, int ei, int ew, int cp,
                                int eaddr, int edata, int ebusy);
        vec_t v;
        v.alu_v = 1'(av);  v.alu_rd = AW'(ard); v.alu_d = DW'(ad);
        v.lsu_v = 1'(lv);  v.lsu_rd = AW'(lrd); v.lsu_d = DW'(ld);
        v.iss_v = 1'(iv);  v.rd = AW'(ird); v.rs1 = AW'(r1); v.rs2 = AW'(r2);
        v.u1 = 1'(u1);     v.u2 = 1'(u2);
        v.e_alu = 1'(ea);  v.e_lsu = 1'(el); v.e_iss = 1'(ei); v.e_we = 1'(ew);
        v.chk_port = 1'(cp); v.e_addr = AW'(eaddr); v.e_data = DW'(edata);
        v.e_busy = NR'(ebusy);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid_i = 1'b0; alu_rd_addr_i = '0; alu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_addr_i = '0; lsu_data_i = '0;
        iss_valid_i = 1'b0; iss_rd_addr_i = '0; iss_rs1_addr_i = '0; iss_rs2_addr_i = '0;
        iss_uses_rs1_i = 1'b0; iss_uses_rs2_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n_i = 1'b0;
        repeat (2) next_cycle();
        rst_n_i = 1'b1;
    endtask

    // Reference model state for the randomized run.
    bit            mb [NR];
    int            m_last;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    function automatic logic [AW-1:0] pick_rd();
        int cand [$];
        for (int r = 1; r < 8; r++) if (mb[r]) cand.push_back(r);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            return AW'(cand[$urandom_range(0, cand.size() - 1)]);
        return AW'($urandom_range(0, 7));
    endfunction

    vec_t tbl [21];

    initial begin
        rst_n_i = 1'b0;
        drive_idle();
        #1;
        chk("reset.we",     64'(rf_we_o),      64'd0);
        chk("reset.addr",   64'(rf_rd_addr_o), 64'd0);
        chk("reset.data",   64'(rf_rd_o),      64'd0);
        chk("reset.busy",   64'(busy_o),       64'd0);
        chk("reset.issrdy", 64'(iss_ready_o),  64'd1);

        //            alu          lsu          issue rd rs1 rs2 u1 u2   ea el ei ew cp addr data busy
        tbl[0]  = mk(1,5,'hDEADBEEF, 0,0,0,     0,0,0,0,0,0,  1,0,1,0, 1,0,0,0);
        tbl[1]  = mk(0,0,0,          0,0,0,     0,0,0,0,0,0,  0,0,1,1, 1,5,'hDEADBEEF,0);
        tbl[2]  = mk(0,0,0,          0,0,0,     0,0,0,0,0,0,  0,0,1,0, 1,5,'hDEADBEEF,0);
        tbl[3]  = mk(1,1,'h11,       1,2,'h22,  0,0,0,0,0,0,  0,1,1,0, 1,5,'hDEADBEEF,0);
        tbl[4]  = mk(1,1,'h11,       1,3,'h33,  0,0,0,0,0,0,  1,0,1,1, 1,2,'h22,0);
        tbl[5]  = mk(0,0,0,          1,3,'h33,  0,0,0,0,0,0,  0,1,1,1, 1,1,'h11,0);
        tbl[6]  = mk(0,0,0,          0,0,0,     0,0,0,0,0,0,  0,0,1,1, 1,3,'h33,0);
        tbl[7]  = mk(0,0,0,          0,0,0,     0,0,0,0,0,0,  0,0,1,0, 1,3,'h33,0);
        tbl[8]  = mk(0,0,0,          0,0,0,     1,7,0,0,0,0,  0,0,1,0, 1,3,'h33,0);
        tbl[9]  = mk(0,0,0,          0,0,0,     1,0,7,0,1,0,  0,0,0,0, 1,3,'h33,'h80);
        tbl[10] = mk(0,0,0,          1,7,'h77,  1,0,7,0,1,0,  0,1,0,0, 1,3,'h33,'h80);
        tbl[11] = mk(0,0,0,          0,0,0,     1,0,7,0,1,0,  0,0,0,1, 1,7,'h77,'h80);
        tbl[12] = mk(0,0,0,          0,0,0,     1,0,7,0,1,0,  0,0,1,0, 1,7,'h77,0);
        tbl[13] = mk(1,0,'h55,       0,0,0,     1,0,0,0,0,0,  1,0,1,0, 1,7,'h77,0);
        tbl[14] = mk(0,0,0,          0,0,0,     0,0,0,0,0,0,  0,0,1,0, 0,0,0,0);
        tbl[15] = mk(1,9,'h99,       0,0,0,     0,0,0,0,0,0,  1,0,1,0, 0,0,0,0);
        tbl[16] = mk(0,0,0,          0,0,0,     1,9,0,0,0,0,  0,0,1,1, 1,9,'h99,0);
        tbl[17] = mk(0,0,0,          0,0,0,     1,9,0,0,0,0,  0,0,0,0, 1,9,'h99,'h200);
        tbl[18] = mk(0,0,0,          1,9,'h9A,  1,0,0,9,0,1,  0,1,0,0, 1,9,'h99,'h200);
        tbl[19] = mk(0,0,0,          0,0,0,     1,0,9,0,0,0,  0,0,1,1, 1,9,'h9A,'h200);
        tbl[20] = mk(0,0,0,          0,0,0,     0,0,0,0,0,0,  0,0,1,0, 1,9,'h9A,0);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            alu_valid_i = tbl[i].alu_v; alu_rd_addr_i = tbl[i].alu_rd; alu_data_i = tbl[i].alu_d;
            lsu_valid_i = tbl[i].lsu_v; lsu_rd_addr_i = tbl[i].lsu_rd; lsu_data_i = tbl[i].lsu_d;
            iss_valid_i = tbl[i].iss_v; iss_rd_addr_i = tbl[i].rd;
            iss_rs1_addr_i = tbl[i].rs1; iss_rs2_addr_i = tbl[i].rs2;
            iss_uses_rs1_i = tbl[i].u1;  iss_uses_rs2_i = tbl[i].u2;
            #1;
            chk($sformatf("vec%0d.alu_rdy", i), 64'(alu_ready_o), 64'(tbl[i].e_alu));
            chk($sformatf("vec%0d.lsu_rdy", i), 64'(lsu_ready_o), 64'(tbl[i].e_lsu));
            chk($sformatf("vec%0d.iss_rdy", i), 64'(iss_ready_o), 64'(tbl[i].e_iss));
            chk($sformatf("vec%0d.we", i),      64'(rf_we_o),     64'(tbl[i].e_we));
            chk($sformatf("vec%0d.busy", i),    64'(busy_o),      64'(tbl[i].e_busy));
            if (tbl[i].chk_port) begin
                chk($sformatf("vec%0d.addr", i), 64'(rf_rd_addr_o), 64'(tbl[i].e_addr));
                chk($sformatf("vec%0d.data", i), 64'(rf_rd_o),      64'(tbl[i].e_data));
            end
            next_cycle();
        end

        // Continuous tie from reset: ALU, LSU, ALU, LSU with back-to-back writes.
        do_reset();
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd1; alu_data_i = 32'h101;
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd2; lsu_data_i = 32'h202;
        #1;
        chk("rr0.alu", 64'(alu_ready_o), 64'd1);
        chk("rr0.lsu", 64'(lsu_ready_o), 64'd0);
        chk("rr0.we",  64'(rf_we_o),     64'd0);
        next_cycle();
        alu_rd_addr_i = 5'd3; alu_data_i = 32'h303;
        #1;
        chk("rr1.alu",  64'(alu_ready_o),  64'd0);
        chk("rr1.lsu",  64'(lsu_ready_o),  64'd1);
        chk("rr1.addr", 64'(rf_rd_addr_o), 64'd1);
        chk("rr1.we",   64'(rf_we_o),      64'd1);
        next_cycle();
        lsu_rd_addr_i = 5'd4; lsu_data_i = 32'h404;
        #1;
        chk("rr2.alu",  64'(alu_ready_o),  64'd1);
        chk("rr2.lsu",  64'(lsu_ready_o),  64'd0);
        chk("rr2.addr", 64'(rf_rd_addr_o), 64'd2);
        chk("rr2.we",   64'(rf_we_o),      64'd1);
        next_cycle();
        alu_valid_i = 1'b0;
        #1;
        chk("rr3.lsu",  64'(lsu_ready_o),  64'd1);
        chk("rr3.addr", 64'(rf_rd_addr_o), 64'd3);
        chk("rr3.we",   64'(rf_we_o),      64'd1);
        next_cycle();
        drive_idle();
        #1;
        chk("rr4.addr", 64'(rf_rd_addr_o), 64'd4);
        chk("rr4.data", 64'(rf_rd_o),      64'h404);
        chk("rr4.we",   64'(rf_we_o),      64'd1);
        next_cycle();
        chk("rr5.we",   64'(rf_we_o),      64'd0);

        // Reset mid-stream with registers 8..11 busy and a write on the port.
        do_reset();
        for (int r = 8; r < 12; r++) begin
            iss_valid_i = 1'b1; iss_rd_addr_i = AW'(r);
            if (r == 11) begin
                alu_valid_i = 1'b1; alu_rd_addr_i = 5'd5; alu_data_i = 32'h5555;
            end
            #1;
            chk($sformatf("mid.iss%0d", r), 64'(iss_ready_o), 64'd1);
            next_cycle();
        end
        drive_idle();
        #1;
        chk("mid.busy",  64'(busy_o),  64'hF00);
        chk("mid.we",    64'(rf_we_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        chk("rst.we",     64'(rf_we_o),      64'd0);
        chk("rst.addr",   64'(rf_rd_addr_o), 64'd0);
        chk("rst.data",   64'(rf_rd_o),      64'd0);
        chk("rst.busy",   64'(busy_o),       64'd0);
        chk("rst.issrdy", 64'(iss_ready_o),  64'd1);
        lsu_valid_i = 1'b1;
        #1;
        chk("rst.solelsu", 64'(lsu_ready_o), 64'd1);
        next_cycle();
        rst_n_i = 1'b1;
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd1; lsu_rd_addr_i = 5'd2;
        #1;
        chk("rst.tie.alu", 64'(alu_ready_o), 64'd1);
        chk("rst.tie.lsu", 64'(lsu_ready_o), 64'd0);
        next_cycle();

        // Randomized run against the reference model.
        do_reset();
        for (int r = 0; r < NR; r++) mb[r] = 1'b0;
        m_last = 2; m_we = 1'b0; m_addr = '0; m_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int            winner;
            bit            exp_iss;
            logic [NR-1:0] exp_busy;
            logic [AW-1:0] w_rd;
            logic [DW-1:0] w_d;
            if (!alu_valid_i) begin
                alu_valid_i = ($urandom_range(0, 2) != 0);
                alu_rd_addr_i = pick_rd(); alu_data_i = $urandom;
            end
            if (!lsu_valid_i) begin
                lsu_valid_i = ($urandom_range(0, 2) != 0);
                lsu_rd_addr_i = pick_rd(); lsu_data_i = $urandom;
            end
            iss_valid_i    = ($urandom_range(0, 1) != 0);
            iss_rd_addr_i  = AW'($urandom_range(0, 7));
            iss_rs1_addr_i = AW'($urandom_range(0, 7));
            iss_rs2_addr_i = AW'($urandom_range(0, 7));
            iss_uses_rs1_i = 1'($urandom_range(0, 1));
            iss_uses_rs2_i = 1'($urandom_range(0, 1));
            #1;
            // 1 = ALU, 2 = LSU; on a tie the one not granted last time wins.
            if (alu_valid_i && lsu_valid_i) winner = (m_last == 1) ? 2 : 1;
            else if (alu_valid_i)           winner = 1;
            else if (lsu_valid_i)           winner = 2;
            else                            winner = 0;
            exp_iss = !(iss_uses_rs1_i && mb[iss_rs1_addr_i]) &&
                      !(iss_uses_rs2_i && mb[iss_rs2_addr_i]) && !mb[iss_rd_addr_i];
            for (int r = 0; r < NR; r++) exp_busy[r] = mb[r];
            chk("rnd.alu_rdy", 64'(alu_ready_o), 64'(winner == 1));
            chk("rnd.lsu_rdy", 64'(lsu_ready_o), 64'(winner == 2));
            chk("rnd.iss_rdy", 64'(iss_ready_o), 64'(exp_iss));
            chk("rnd.we",      64'(rf_we_o),     64'(m_we));
            chk("rnd.busy",    64'(busy_o),      64'(exp_busy));
            if (m_we) begin
                chk("rnd.addr", 64'(rf_rd_addr_o), 64'(m_addr));
                chk("rnd.data", 64'(rf_rd_o),      64'(m_data));
            end
            if (m_we) mb[m_addr] = 1'b0;
            if (iss_valid_i && exp_iss && iss_rd_addr_i != 0) mb[iss_rd_addr_i] = 1'b1;
            w_rd = (winner == 1) ? alu_rd_addr_i : lsu_rd_addr_i;
            w_d  = (winner == 1) ? alu_data_i    : lsu_data_i;
            m_we = (winner != 0) && (w_rd != 0);
            if (m_we) begin
                m_addr = w_rd; m_data = w_d;
            end
            if (winner != 0) m_last = winner;
            next_cycle();
            if (winner == 1) alu_valid_i = 1'b0;
            if (winner == 2) lsu_valid_i = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
